board_reset_sequencer: RTL and testbench

- Parametrised reset front-end for board toplevels (DE1 and successors). Replaces the single-flop "switch XOR key, AND pll_locked" reset logic.
- Synchronises and debounces N board reset sources and qualifies PLL lock, with a settle delay on acquisition and immediate action on loss.
- Stretches the reset, then releases M active-low reset outputs in a staged sequence (e.g. SDRAM controller first, then CPU/UART).
- Reports the cause of the last reset and a reset-event count for LEDs/HEX display.

---
 rtl/board_reset_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_board_reset_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/board_reset_sequencer.sv
// Board reset front-end: synchronises and debounces reset sources, qualifies PLL lock,
// stretches the reset and releases staged active-low resets, reporting cause and event count.
module board_reset_sequencer #(
    parameter int unsigned              NUM_SOURCES        = 2,
    parameter logic [NUM_SOURCES-1:0]   SRC_ACTIVE_LOW     = NUM_SOURCES'(2'b01),
    parameter int unsigned              DEBOUNCE_CYCLES    = 16,
    parameter int unsigned              LOCK_SETTLE_CYCLES = 32,
    parameter int unsigned              STRETCH_CYCLES     = 64,
    parameter int unsigned              NUM_STAGES         = 2,
    parameter int unsigned              STAGE_GAP          = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] src_in,
    input  logic                   pll_locked,
    output logic [NUM_STAGES-1:0]  rst_n_out,
    output logic                   all_released,
    output logic [7:0]             reset_count,
    output logic [NUM_SOURCES:0]   last_cause
);

    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LOCK_W  = $clog2(LOCK_SETTLE_CYCLES + 1);
    localparam int unsigned SEQ_MAX = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
    localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int unsigned K_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_STRETCH = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    logic [NUM_SOURCES-1:0] src_meta, src_sync;
    logic                   lock_meta, lock_sync;
    logic [NUM_SOURCES-1:0] deb_q, deb_d, act;
    logic [DEB_W-1:0]       deb_cnt_q [NUM_SOURCES];
    logic [DEB_W-1:0]       deb_cnt_d [NUM_SOURCES];
    logic [LOCK_W-1:0]      lock_cnt_q, lock_cnt_d;
    logic                   lock_ok_q, lock_ok_d;
    logic                   req;

    logic [1:0]             state_q, state_d;
    logic [SEQ_W-1:0]       seq_cnt_q, seq_cnt_d;
    logic [K_W-1:0]         stage_q, stage_d;
    logic [NUM_STAGES-1:0]  rst_n_d;
    logic                   all_released_d;
    logic [7:0]             reset_count_d;
    logic [NUM_SOURCES:0]   last_cause_d;
    logic                   event_c;

    // All state, including registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            src_meta     <= SRC_ACTIVE_LOW;
            src_sync     <= SRC_ACTIVE_LOW;
            lock_meta    <= 1'b0;
            lock_sync    <= 1'b0;
            deb_q        <= '1;
            for (int i = 0; i < int'(NUM_SOURCES); i++) deb_cnt_q[i] <= '0;
            lock_cnt_q   <= '0;
            lock_ok_q    <= 1'b0;
            state_q      <= ST_ASSERT;
            seq_cnt_q    <= '0;
            stage_q      <= '0;
            rst_n_out    <= '0;
            all_released <= 1'b0;
            reset_count  <= 8'd0;
            last_cause   <= '0;
        end else begin
            src_meta     <= src_in;
            src_sync     <= src_meta;
            lock_meta    <= pll_locked;
            lock_sync    <= lock_meta;
            deb_q        <= deb_d;
            for (int i = 0; i < int'(NUM_SOURCES); i++) deb_cnt_q[i] <= deb_cnt_d[i];
            lock_cnt_q   <= lock_cnt_d;
            lock_ok_q    <= lock_ok_d;
            state_q      <= state_d;
            seq_cnt_q    <= seq_cnt_d;
            stage_q      <= stage_d;
            rst_n_out    <= rst_n_d;
            all_released <= all_released_d;
            reset_count  <= reset_count_d;
            last_cause   <= last_cause_d;
        end
    end

    // Per-source debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        act   = src_sync ^ SRC_ACTIVE_LOW;
        deb_d = deb_q;
        for (int i = 0; i < int'(NUM_SOURCES); i++) begin
            deb_cnt_d[i] = '0;
            if (act[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = act[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    // Lock qualification: slow to accept, instant to drop
    always_comb begin
        lock_cnt_d = '0;
        lock_ok_d  = 1'b0;
        if (lock_sync) begin
            lock_cnt_d = lock_cnt_q;
            lock_ok_d  = lock_ok_q;
            if (!lock_ok_q) begin
                if (lock_cnt_q == LOCK_W'(LOCK_SETTLE_CYCLES)) begin
                    lock_ok_d  = 1'b1;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
        end
    end

    // A low synced lock requests reset in the same cycle that lock_ok is being cleared
    assign req = (|deb_q) | ~(lock_ok_q & lock_sync);

    // Sequencer next state and registered outputs
    always_comb begin
        state_d   = state_q;
        seq_cnt_d = seq_cnt_q;
        stage_d   = stage_q;
        rst_n_d   = rst_n_out;
        event_c   = 1'b0;

        case (state_q)
            ST_ASSERT: begin
                rst_n_d   = '0;
                seq_cnt_d = '0;
                stage_d   = '0;
                if (!req) state_d = ST_STRETCH;
            end
            ST_STRETCH: begin
                if (seq_cnt_q == SEQ_W'(STRETCH_CYCLES - 1)) begin
                    seq_cnt_d  = '0;
                    stage_d    = '0;
                    rst_n_d[0] = 1'b1;
                    state_d    = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            ST_RELEASE: begin
                if (seq_cnt_q == SEQ_W'(STAGE_GAP - 1)) begin
                    seq_cnt_d = '0;
                    stage_d   = stage_q + K_W'(1);
                    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
                        if (i == 32'(stage_q) + 32'd1) rst_n_d[i] = 1'b1;
                    end
                    if (32'(stage_q) + 32'd2 == NUM_STAGES) state_d = ST_RUN;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            ST_RUN: begin
                rst_n_d = '1;
            end
            default: begin
                state_d = ST_ASSERT;
                rst_n_d = '0;
            end
        endcase

        // Any re-request restarts the whole sequence
        if (req && state_q != ST_ASSERT) begin
            state_d   = ST_ASSERT;
            seq_cnt_d = '0;
            stage_d   = '0;
            rst_n_d   = '0;
            event_c   = 1'b1;
        end

        all_released_d = (state_d == ST_RUN);
        reset_count_d  = reset_count;
        last_cause_d   = last_cause;
        if (event_c) begin
            if (reset_count != 8'hFF) reset_count_d = reset_count + 8'd1;
            last_cause_d = {~lock_ok_d, deb_d};
        end
    end

endmodule

// File: tb/tb_board_reset_sequencer.sv
// Bench for board_reset_sequencer: a timeline table of input/expectation records feeding a
// scoreboard, plus hand-written saturation and global-reset sequences.
module tb_board_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] src_in;
    logic       pll_locked;
    logic [1:0] rst_n_out;
    logic       all_released;
    logic [7:0] reset_count;
    logic [2:0] last_cause;

    board_reset_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .src_in       (src_in),
        .pll_locked   (pll_locked),
        .rst_n_out    (rst_n_out),
        .all_released (all_released),
        .reset_count  (reset_count),
        .last_cause   (last_cause)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [1:0]  src;
        logic        pll;
        int unsigned cycles;
        logic [1:0]  rst;
        logic        all_rel;
        logic [7:0]  cnt;
        logic [2:0]  cause;
    } vec_t;

    typedef struct {
        string       name;
        int unsigned at;
        logic [13:0] exp;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    function automatic void check(string name, logic [13:0] exp, logic [13:0] act);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s cyc=%0d: got rst_n=%b all=%b cnt=%0d cause=%b, want rst_n=%b all=%b cnt=%0d cause=%b",
                     name, cyc, act[13:12], act[11], act[10:3], act[2:0],
                     exp[13:12], exp[11], exp[10:3], exp[2:0]);
        end
    endfunction

    function automatic void expect_at(string name, int unsigned at, logic [1:0] rst, logic all_rel,
                                      logic [7:0] cnt, logic [2:0] cause);
        exp_t e;
        e.name = name;
        e.at   = at;
        e.exp  = {rst, all_rel, cnt, cause};
        sb.push_back(e);
    endfunction

    function automatic void add(string name, logic [1:0] src, logic pll, int unsigned cycles,
                                logic [1:0] rst, logic all_rel, logic [7:0] cnt, logic [2:0] cause);
        vec_t v;
        v.name = name; v.src = src; v.pll = pll; v.cycles = cycles;
        v.rst = rst; v.all_rel = all_rel; v.cnt = cnt; v.cause = cause;
        vecs.push_back(v);
    endfunction

    // Scoreboard: compare on the falling edge once the expected cycle arrives
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, e.exp, {rst_n_out, all_released, reset_count, last_cause});
        end
    end

    initial begin
        repeat (30000) @(posedge clk);
        checks++;
        $display("FAIL watchdog: simulation ran past cycle %0d, want completion", cyc);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        int unsigned c;
        int          exp_cnt;

        // Timeline from release of global reset; comment edges are counted from edge 0
        add("por_edge0",       2'b01, 1'b1,  1, 2'b00, 1'b0, 8'd0, 3'b000);
        add("por_stretch",     2'b01, 1'b1, 98, 2'b00, 1'b0, 8'd0, 3'b000); // e98
        add("por_rel0",        2'b01, 1'b1,  1, 2'b01, 1'b0, 8'd0, 3'b000); // e99
        add("por_gap",         2'b01, 1'b1,  7, 2'b01, 1'b0, 8'd0, 3'b000);
        add("por_run",         2'b01, 1'b1,  1, 2'b11, 1'b1, 8'd0, 3'b000); // e107
        add("glitch15",        2'b00, 1'b1, 15, 2'b11, 1'b1, 8'd0, 3'b000);
        add("glitch_quiet",    2'b01, 1'b1, 20, 2'b11, 1'b1, 8'd0, 3'b000); // e142
        add("src0_deb",        2'b00, 1'b1, 18, 2'b11, 1'b1, 8'd0, 3'b000);
        add("src0_assert",     2'b00, 1'b1,  1, 2'b00, 1'b0, 8'd1, 3'b001); // +19
        add("src0_release",    2'b01, 1'b1, 30, 2'b00, 1'b0, 8'd1, 3'b001);
        add("src0_stretch",    2'b01, 1'b1, 52, 2'b00, 1'b0, 8'd1, 3'b001); // e243
        add("src0_rel0",       2'b01, 1'b1,  1, 2'b01, 1'b0, 8'd1, 3'b001);
        add("src0_run",        2'b01, 1'b1,  8, 2'b11, 1'b1, 8'd1, 3'b001); // e252
        add("lock_drop",       2'b01, 1'b0,  1, 2'b11, 1'b1, 8'd1, 3'b001);
        add("lock_wait",       2'b01, 1'b1,  1, 2'b11, 1'b1, 8'd1, 3'b001);
        add("lock_assert",     2'b01, 1'b1,  1, 2'b00, 1'b0, 8'd2, 3'b100); // +3
        add("lock_settle",     2'b01, 1'b1, 85, 2'b00, 1'b0, 8'd2, 3'b100); // e340
        add("midrel_req",      2'b11, 1'b1, 13, 2'b01, 1'b0, 8'd2, 3'b100); // e353
        add("midrel_deb",      2'b11, 1'b1,  5, 2'b01, 1'b0, 8'd2, 3'b100);
        add("midrel_assert",   2'b11, 1'b1,  1, 2'b00, 1'b0, 8'd3, 3'b010); // e359
        add("midrel_hold",     2'b11, 1'b1,  1, 2'b00, 1'b0, 8'd3, 3'b010);
        add("midrel_restart",  2'b01, 1'b1, 82, 2'b00, 1'b0, 8'd3, 3'b010); // e442
        add("midrel_rel0",     2'b01, 1'b1,  1, 2'b01, 1'b0, 8'd3, 3'b010);
        add("midrel_run",      2'b01, 1'b1,  8, 2'b11, 1'b1, 8'd3, 3'b010); // e451
        add("simul_drop",      2'b00, 1'b0,  1, 2'b11, 1'b1, 8'd3, 3'b010);
        add("simul_wait",      2'b00, 1'b1,  1, 2'b11, 1'b1, 8'd3, 3'b010);
        add("simul_assert",    2'b00, 1'b1,  1, 2'b00, 1'b0, 8'd4, 3'b100);
        add("simul_no_event",  2'b00, 1'b1, 20, 2'b00, 1'b0, 8'd4, 3'b100);
        add("simul_release",   2'b01, 1'b1, 82, 2'b00, 1'b0, 8'd4, 3'b100); // e556
        add("simul_rel0",      2'b01, 1'b1,  1, 2'b01, 1'b0, 8'd4, 3'b100);
        add("simul_run",       2'b01, 1'b1,  8, 2'b11, 1'b1, 8'd4, 3'b100); // e565

        reset      = 1'b1;
        src_in     = 2'b01;
        pll_locked = 1'b1;
        expect_at("reset_state", 2, 2'b00, 1'b0, 8'd0, 3'b000);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            src_in     = vecs[i].src;
            pll_locked = vecs[i].pll;
            expect_at(vecs[i].name, cyc + vecs[i].cycles, vecs[i].rst, vecs[i].all_rel,
                      vecs[i].cnt, vecs[i].cause);
            repeat (vecs[i].cycles) @(negedge clk);
        end

        // Repeated lock-loss events drive the event counter into saturation
        for (int i = 0; i < 260; i++) begin
            exp_cnt = (5 + i > 255) ? 255 : 5 + i;
            c = cyc;
            pll_locked = 1'b0;
            expect_at("sat_event", c + 3, 2'b00, 1'b0, 8'(exp_cnt), 3'b100);
            @(negedge clk);
            pll_locked = 1'b1;
            repeat (39) @(negedge clk);
        end
        c = cyc;
        expect_at("sat_rel0", c + 61, 2'b01, 1'b0, 8'd255, 3'b100);
        expect_at("sat_run",  c + 69, 2'b11, 1'b1, 8'd255, 3'b100);
        repeat (69) @(negedge clk);

        // Global reset from RUN clears everything on the next edge and is not an event
        c = cyc;
        reset = 1'b1;
        expect_at("greset_clear", c + 1, 2'b00, 1'b0, 8'd0, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        expect_at("greset_stretch", c + 2 + 98,  2'b00, 1'b0, 8'd0, 3'b000);
        expect_at("greset_rel0",    c + 2 + 106, 2'b01, 1'b0, 8'd0, 3'b000);
        expect_at("greset_run",     c + 2 + 107, 2'b11, 1'b1, 8'd0, 3'b000);
        repeat (108) @(negedge clk);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
